// File: rtl/shiftreg_4bit.sv
// Parallel-load, bidirectional serial shift register with a remaining-bits counter.
// Optional rotate input enabled by defining SHIFTREG_4BIT_ROTATE_EN.
module shiftreg_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             sin,
`ifdef SHIFTREG_4BIT_ROTATE_EN
  input  logic             rotate,
`endif
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] Q,
  output logic             E,
  output logic             empty
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             e_q, e_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             out_bit_s;
  logic             fill_s;

  // Bit leaving the register on a shift, and the bit entering the vacated end
  always_comb begin
    if (dir) begin
      out_bit_s = q_q[WIDTH-1];
    end else begin
      out_bit_s = q_q[0];
    end
`ifdef SHIFTREG_4BIT_ROTATE_EN
    if (rotate) begin
      fill_s = out_bit_s;
    end else begin
      fill_s = sin;
    end
`else
    fill_s = sin;
`endif
  end

  // Next-state logic: load beats shift, otherwise hold
  always_comb begin
    q_d   = q_q;
    e_d   = e_q;
    rem_d = rem_q;
    if (load) begin
      q_d   = A;
      e_d   = 1'b0;
      rem_d = CNT_W'(WIDTH);
    end else if (shift_en) begin
      e_d = out_bit_s;
      if (dir) begin
        q_d = {q_q[WIDTH-2:0], fill_s};
      end else begin
        q_d = {fill_s, q_q[WIDTH-1:1]};
      end
      // Count saturates at zero so shifting an empty register stays legal
      if (rem_q != {CNT_W{1'b0}}) begin
        rem_d = rem_q - CNT_W'(1);
      end else begin
        rem_d = rem_q;
      end
    end else begin
      q_d   = q_q;
      e_d   = e_q;
      rem_d = rem_q;
    end
  end

  // State registers with synchronous clear overriding everything
  always_ff @(posedge clock) begin
    if (clear) begin
      q_q   <= {WIDTH{1'b0}};
      e_q   <= 1'b0;
      rem_q <= {CNT_W{1'b0}};
    end else begin
      q_q   <= q_d;
      e_q   <= e_d;
      rem_q <= rem_d;
    end
  end

  assign Q     = q_q;
  assign E     = e_q;
  assign empty = (rem_q == {CNT_W{1'b0}});

endmodule

// File: tb/tb_shiftreg_4bit.sv
// Randomized and directed self-checking bench for shiftreg_4bit against an
// arithmetic reference model (integer division/modulo instead of bit slicing).
module tb_shiftreg_4bit;

  localparam int W = 4;

  logic         clock;
  logic         clear;
  logic         load;
  logic         shift_en;
  logic         dir;
  logic         sin;
  logic         rotate;
  logic [W-1:0] A;
  logic [W-1:0] Q;
  logic         E;
  logic         empty;

  int n_cmp;
  int n_err;

  // Reference model state
  int q_m;
  int e_m;
  int rem_m;

  shiftreg_4bit #(.WIDTH(W)) dut (
    .clock   (clock),
    .clear   (clear),
    .load    (load),
    .shift_en(shift_en),
    .dir     (dir),
    .sin     (sin),
`ifdef SHIFTREG_4BIT_ROTATE_EN
    .rotate  (rotate),
`endif
    .A       (A),
    .Q       (Q),
    .E       (E),
    .empty   (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare outputs
  task automatic step(input logic clr, input logic ld, input logic se, input logic d,
                      input logic s, input logic rot, input logic [W-1:0] a);
    int outb;
    int fill;
    clear = clr; load = ld; shift_en = se; dir = d; sin = s; rotate = rot; A = a;
    @(posedge clock);
    if (clr) begin
      q_m = 0; e_m = 0; rem_m = 0;
    end else if (ld) begin
      q_m = int'(a); e_m = 0; rem_m = W;
    end else if (se) begin
      if (d) outb = q_m / (1 << (W - 1));
      else   outb = q_m % 2;
      fill = int'(s);
`ifdef SHIFTREG_4BIT_ROTATE_EN
      if (rot) fill = outb;
`endif
      if (d) q_m = (q_m * 2) % (1 << W) + fill;
      else   q_m = q_m / 2 + fill * (1 << (W - 1));
      e_m = outb;
      if (rem_m > 0) rem_m = rem_m - 1;
    end
    #1;
    chk("Q", 32'(Q), 32'(q_m));
    chk("E", 32'(E), 32'(e_m));
    chk("empty", 32'(empty), 32'(rem_m == 0));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    q_m = 0; e_m = 0; rem_m = 0;
    clear = 1'b0; load = 1'b0; shift_en = 1'b0; dir = 1'b0; sin = 1'b0;
    rotate = 1'b0; A = '0;

    // Reset wins over load
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
    chk("rst_Q", 32'(Q), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);

    // Right shift of 1101
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101);
    chk("ld_empty", 32'(empty), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rs1_E", 32'(E), 32'h1);
    chk("rs1_Q", 32'(Q), 32'b0110);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rs3_empty", 32'(empty), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rs4_E", 32'(E), 32'h1);
    chk("rs4_empty", 32'(empty), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rs5_E", 32'(E), 32'h0);

    // Left shift with fill 1
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    chk("ls_Q", 32'(Q), 32'b1111);
    chk("ls_E", 32'(E), 32'h1);

    // Clear mid-shift, then load beats shift
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("mid_clr_Q", 32'(Q), 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0110);
    chk("ld_vs_sh_Q", 32'(Q), 32'b0110);
    chk("ld_vs_sh_E", 32'(E), 32'h0);

    // Drain, hold, then saturating shifts fill with ones
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("sat_empty", 32'(empty), 32'h1);
    chk("sat_Q", 32'(Q), 32'b1100);

`ifdef SHIFTREG_4BIT_ROTATE_EN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("rot_Q", 32'(Q), 32'b1000);
    chk("rot_E", 32'(E), 32'h1);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           W'($urandom_range(0, (1 << W) - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
